// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seg_scan_ctrl display scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN (see seg_scan_ctrl).
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_e;

   localparam int unsigned BCD_W = 4;

   // Width of the digit index; a single digit still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg_scan_presc.sv
// Slot timer: down-counter producing end-of-dead-time and end-of-slot strobes.
// Loaded with PRESCALE-1 when a slot starts; cleared whenever scanning stops.
module seg_scan_presc #(
   parameter int unsigned PRESCALE  = 1000,
   parameter int unsigned BLANK_CYC = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic active_i,
   output logic blank_done_o,
   output logic slot_done_o
);

   localparam int unsigned CW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_TOP   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(PRESCALE - BLANK_CYC);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (start_i) begin
         cnt_d = CNT_TOP;
      end else if (active_i) begin
         cnt_d = (cnt_q == '0) ? CNT_TOP : cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counter runs PRESCALE-1 down to 0: BLANK covers the top BLANK_CYC values.
   assign blank_done_o = active_i && (cnt_q == BLANK_END);
   assign slot_done_o  = active_i && (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan scheduler with per-slot blanking dead-time.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 excluded).
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned PRESCALE   = 1000,
   parameter int unsigned BLANK_CYC  = 8
) (
   input  logic                              CP,
   input  logic                              MRN,
   input  logic                              en,
   input  logic [BCD_W*NUM_DIGITS-1:0]       digit_bcd,
   input  logic [NUM_DIGITS-1:0]             digit_mask,
   output logic [BCD_W-1:0]                  bcd_out,
   output logic [NUM_DIGITS-1:0]             dig_sel,
   output logic                              blank,
   output logic [idx_width(NUM_DIGITS)-1:0]  scan_idx,
   output logic                              frame_tick
);

   localparam int unsigned IW = idx_width(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   scan_state_e             state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    blank_q, blank_d;
   logic                    tick_q, tick_d;

   logic [BCD_W-1:0]        cur_bcd;
   logic                    cur_mask;
   logic                    eff_mask;
   logic                    blank_done, slot_done;

   seg_scan_presc #(
      .PRESCALE  (PRESCALE),
      .BLANK_CYC (BLANK_CYC)
   ) u_presc (
      .clk_i        (CP),
      .rst_ni       (MRN),
      .start_i      (en && (state_q == IDLE)),
      .active_i     (en && (state_q != IDLE)),
      .blank_done_o (blank_done),
      .slot_done_o  (slot_done)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic nz_upper;
`endif

   always_comb begin
      cur_bcd  = '0;
      cur_mask = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            cur_bcd  = digit_bcd[i*BCD_W +: BCD_W];
            cur_mask = digit_mask[i];
         end
      end
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is significant if it or any more-significant digit is nonzero.
      nz_upper = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if ((IW'(i) >= idx_q) && (digit_bcd[i*BCD_W +: BCD_W] != '0)) begin
            nz_upper = 1'b1;
         end
      end
      eff_mask = cur_mask && (nz_upper || (idx_q == '0));
`else
      eff_mask = cur_mask;
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bcd_d   = bcd_q;
      sel_d   = sel_q;
      blank_d = blank_q;
      tick_d  = 1'b0;
      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
         bcd_d   = '0;
         sel_d   = '0;
         blank_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = BLANK;
               idx_d   = '0;
            end
            BLANK: begin
               if (blank_done) begin
                  state_d = SHOW;
                  bcd_d   = cur_bcd;
                  if (eff_mask) begin
                     sel_d   = NUM_DIGITS'(1) << idx_q;
                     blank_d = 1'b0;
                  end else begin
                     sel_d   = '0;
                     blank_d = 1'b1;
                  end
               end
            end
            SHOW: begin
               if (slot_done) begin
                  state_d = BLANK;
                  sel_d   = '0;
                  blank_d = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     idx_d  = '0;
                     tick_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CP or negedge MRN) begin
      if (!MRN) begin
         state_q <= IDLE;
         idx_q   <= '0;
         bcd_q   <= '0;
         sel_q   <= '0;
         blank_q <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bcd_q   <= bcd_d;
         sel_q   <= sel_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
      end
   end

   assign bcd_out    = bcd_q;
   assign dig_sel    = sel_q;
   assign blank      = blank_q;
   assign scan_idx   = idx_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (4 digits, 10-cycle slots, 2 blank).
// Build with LEADING_ZERO_BLANK_EN to exercise leading-zero blanking expectations.
module tb_seg_scan_ctrl;

   logic        CP = 1'b0;
   logic        MRN = 1'b0;
   logic        en = 1'b0;
   logic [15:0] digit_bcd = 16'h0000;
   logic [3:0]  digit_mask = 4'b0000;
   logic [3:0]  bcd_out;
   logic [3:0]  dig_sel;
   logic        blank;
   logic [1:0]  scan_idx;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   seg_scan_ctrl #(
      .NUM_DIGITS (4),
      .PRESCALE   (10),
      .BLANK_CYC  (2)
   ) dut (
      .CP         (CP),
      .MRN        (MRN),
      .en         (en),
      .digit_bcd  (digit_bcd),
      .digit_mask (digit_mask),
      .bcd_out    (bcd_out),
      .dig_sel    (dig_sel),
      .blank      (blank),
      .scan_idx   (scan_idx),
      .frame_tick (frame_tick)
   );

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".dig_sel"}, 32'(dig_sel), 32'h0);
      chk({tag, ".blank"}, 32'(blank), 32'h1);
      chk({tag, ".bcd_out"}, 32'(bcd_out), 32'h0);
      chk({tag, ".scan_idx"}, 32'(scan_idx), 32'h0);
      chk({tag, ".frame_tick"}, 32'(frame_tick), 32'h0);
   endtask

   // Checks one complete 10-cycle slot, starting at the negedge after the
   // edge that enters BLANK. Optionally rewrites digit_bcd mid-SHOW.
   task automatic check_slot(input int idx, input logic [3:0] exp_bcd, input bit shown,
                             input bit ft, input bit chg, input logic [15:0] newv);
      logic [3:0] exp_sel;
      for (int c = 0; c < 10; c++) begin
         @(negedge CP);
         if (chg && c == 5) digit_bcd = newv;
         exp_sel = (c >= 2 && shown) ? (4'b0001 << idx) : 4'b0000;
         chk($sformatf("slot%0d.c%0d.dig_sel", idx, c), 32'(dig_sel), 32'(exp_sel));
         chk($sformatf("slot%0d.c%0d.blank", idx, c), 32'(blank), (c < 2 || !shown) ? 32'h1 : 32'h0);
         chk($sformatf("slot%0d.c%0d.scan_idx", idx, c), 32'(scan_idx), 32'(idx));
         chk($sformatf("slot%0d.c%0d.frame_tick", idx, c), 32'(frame_tick),
             (c == 0 && ft) ? 32'h1 : 32'h0);
         if (c >= 2)
            chk($sformatf("slot%0d.c%0d.bcd_out", idx, c), 32'(bcd_out), 32'(exp_bcd));
      end
   endtask

   initial begin
      // Reset, then en low for 5 cycles
      repeat (2) @(negedge CP);
      chk_idle("reset");
      MRN = 1'b1;
      digit_bcd  = 16'h4321;
      digit_mask = 4'b1111;
      repeat (5) @(negedge CP);
      chk_idle("en_low");

      // First frame straight out of IDLE: no frame_tick on slot 0
      en = 1'b1;
      check_slot(0, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(2, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0);

      // Snapshot: digit 0 changes mid-SHOW, shows old value this frame
      check_slot(0, 4'h1, 1'b1, 1'b1, 1'b1, 16'h4327);
      check_slot(1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(2, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0);

      // Mask digit 2 dark; slot length unchanged
      digit_mask = 4'b1011;
      check_slot(1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(2, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0);
      digit_mask = 4'b1111;
      check_slot(1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);

      // Abort mid-SHOW of digit 2
      repeat (5) @(negedge CP);
      chk("abort.pre.dig_sel", 32'(dig_sel), 32'h4);
      chk("abort.pre.scan_idx", 32'(scan_idx), 32'h2);
      en = 1'b0;
      @(negedge CP);
      chk_idle("abort");
      en = 1'b1;
      check_slot(0, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);

      // Asynchronous reset mid-SHOW of digit 2
      repeat (6) @(negedge CP);
      chk("mrn.pre.dig_sel", 32'(dig_sel), 32'h4);
      MRN = 1'b0;
      #1;
      chk_idle("mrn_async");
      @(negedge CP);
      chk_idle("mrn_held");
      MRN = 1'b1;
      check_slot(0, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(2, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0);

      // Pass-through of non-BCD codes, then leading-zero patterns
      digit_bcd = 16'hF327;
      check_slot(3, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0);
      digit_bcd = 16'h0050;
      check_slot(0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0);
      check_slot(1, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
      check_slot(2, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
`else
      check_slot(2, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
`endif
      digit_bcd = 16'h0000;
      check_slot(0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
      check_slot(1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_slot(2, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
`else
      check_slot(1, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(2, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      check_slot(3, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
`endif
      check_slot(0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
